river_crossing: RTL and testbench

RIVER_CROSSING -- requirements
Module: river_crossing

---
 rtl/river_pkg.sv | 33 +++
 rtl/river_check.sv | 68 ++++++
 rtl/river_crossing.sv | 190 +++++++++++++++++++
 tb/tb_river_crossing.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
`default_nettype none
// ============================================================================
// Module      : river_pkg
// Description : Shared types and constants for the river-crossing puzzle
//               engine: controller state encoding, rejection reason codes
//               and the classic wolf/sheep/cabbage conflict matrix.
// Revision    : 1.0 - initial release
// ============================================================================
package river_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_SOLVED = 2'd3
  } fsm_t;

  // Rejection reasons, numerically fixed because they are visible on a port.
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CAP      = 3'd1,
    ERR_SIDE     = 3'd2,
    ERR_CONFLICT = 3'd3,
    ERR_LIMIT    = 3'd4
  } err_t;

  // Items: 2 = wolf, 1 = sheep, 0 = cabbage.
  // Bit i*3+j set means item i harms item j: (2,1) -> bit 7, (1,0) -> bit 3.
  localparam logic [8:0] DEFAULT_CONFLICT = 9'h088;

endpackage : river_pkg
`default_nettype wire

// File: rtl/river_check.sv
`default_nettype none
// ============================================================================
// Module      : river_check
// Description : Purely combinational legality check of one crossing.
//               Reports, in priority order, boat over capacity, an item
//               selected from the wrong bank, or a conflicting pair left
//               behind on the bank the farmer departs from.
// Ports       : i_state [N_ITEMS:0]   {farmer, items}; 0 = near, 1 = far
//               i_items [N_ITEMS-1:0] items the farmer takes along
//               o_err                 ERR_NONE / ERR_CAP / ERR_SIDE /
//                                     ERR_CONFLICT
// Revision    : 1.0 - initial release
// ============================================================================
module river_check
  import river_pkg::*;
#(
  parameter int                         N_ITEMS  = 3,
  parameter int                         BOAT_CAP = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT = (N_ITEMS*N_ITEMS)'(DEFAULT_CONFLICT)
) (
  input  logic [N_ITEMS:0]   i_state,
  input  logic [N_ITEMS-1:0] i_items,
  output err_t               o_err
);

  localparam int CW = $clog2(N_ITEMS + 1);

  logic               w_farmer;
  logic [CW-1:0]      w_pop;
  logic               w_side;
  logic               w_conflict;
  logic [N_ITEMS-1:0] w_left;

  assign w_farmer = i_state[N_ITEMS];

  always_comb begin
    w_pop      = '0;
    w_side     = 1'b0;
    w_conflict = 1'b0;
    w_left     = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      w_pop     = w_pop + CW'(i_items[i]);
      w_side    = w_side | (i_items[i] & (i_state[i] != w_farmer));
      // Items still sharing the departure bank once the boat has left.
      w_left[i] = (i_state[i] == w_farmer) & ~i_items[i];
    end
    for (int i = 0; i < N_ITEMS; i++) begin
      for (int j = 0; j < N_ITEMS; j++) begin
        if (i != j) begin
          w_conflict = w_conflict | (w_left[i] & w_left[j] & CONFLICT[i*N_ITEMS+j]);
        end
      end
    end
  end

  always_comb begin
    o_err = ERR_NONE;
    if (w_pop > CW'(BOAT_CAP)) begin
      o_err = ERR_CAP;
    end else if (w_side) begin
      o_err = ERR_SIDE;
    end else if (w_conflict) begin
      o_err = ERR_CONFLICT;
    end
  end

endmodule : river_check
`default_nettype wire

// File: rtl/river_crossing.sv
`default_nettype none
// ============================================================================
// Module      : river_crossing
// Description : Move-by-move referee for the river-crossing puzzle. A move
//               is accepted in IDLE, evaluated in CHECK and, if legal,
//               applied in COMMIT. Illegal moves pulse o_move_err and record
//               the reason; legal moves pulse o_move_ok and advance the
//               move counter. Reaching the all-far-bank position parks the
//               controller in SOLVED until i_restart.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               i_move_valid   move request
//               i_move_items   items to carry (zero = farmer alone)
//               i_restart      return to start from IDLE or SOLVED
//               o_move_ready   request can be accepted (IDLE)
//               o_state        {farmer, items}; 1 = far bank
//               o_move_ok      one-cycle pulse, move committed
//               o_move_err     one-cycle pulse, move rejected
//               o_err_code     reason of the most recent rejection
//               o_move_count   number of committed moves
//               o_solved       puzzle solved
// Revision    : 1.0 - initial release
// ============================================================================
module river_crossing
  import river_pkg::*;
#(
  parameter int                         N_ITEMS   = 3,
  parameter int                         BOAT_CAP  = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT  = (N_ITEMS*N_ITEMS)'(DEFAULT_CONFLICT),
  parameter int                         MAX_MOVES = 15,
  localparam int                        CNT_W     = $clog2(MAX_MOVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_move_valid,
  input  logic [N_ITEMS-1:0] i_move_items,
  input  logic               i_restart,
  output logic               o_move_ready,
  output logic [N_ITEMS:0]   o_state,
  output logic               o_move_ok,
  output logic               o_move_err,
  output logic [2:0]         o_err_code,
  output logic [CNT_W-1:0]   o_move_count,
  output logic               o_solved
);

  fsm_t               r_fsm;
  fsm_t               w_fsm_next;
  logic [N_ITEMS-1:0] r_items;
  logic [N_ITEMS:0]   r_state;
  logic [CNT_W-1:0]   r_count;
  err_t               r_err_code;
  logic               r_move_ok;
  logic               r_move_err;

  err_t               w_chk_err;
  err_t               w_err;
  logic               w_at_limit;
  logic [N_ITEMS:0]   w_state_next;
  logic               w_accept;
  logic               w_restart;
  logic               w_reject;
  logic               w_commit;

  river_check #(
    .N_ITEMS  (N_ITEMS),
    .BOAT_CAP (BOAT_CAP),
    .CONFLICT (CONFLICT)
  ) u_check (
    .i_state (r_state),
    .i_items (r_items),
    .o_err   (w_chk_err)
  );

  // The move limit outranks every other reason, so it is folded in here
  // rather than inside the position-only checker.
  assign w_at_limit   = (r_count == CNT_W'(MAX_MOVES));
  assign w_err        = w_at_limit ? ERR_LIMIT : w_chk_err;
  assign w_state_next = r_state ^ {1'b1, r_items};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_restart  = 1'b0;
    w_reject   = 1'b0;
    w_commit   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        // Restart takes precedence over a simultaneous move request.
        if (i_restart) begin
          w_restart = 1'b1;
        end else if (i_move_valid) begin
          w_accept   = 1'b1;
          w_fsm_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_err != ERR_NONE) begin
          w_reject   = 1'b1;
          w_fsm_next = S_IDLE;
        end else begin
          w_fsm_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit   = 1'b1;
        w_fsm_next = (w_state_next == '1) ? S_SOLVED : S_IDLE;
      end
      S_SOLVED: begin
        if (i_restart) begin
          w_restart  = 1'b1;
          w_fsm_next = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_items    <= '0;
      r_state    <= '0;
      r_count    <= '0;
      r_err_code <= ERR_NONE;
      r_move_ok  <= 1'b0;
      r_move_err <= 1'b0;
    end else begin
      r_move_ok  <= w_commit;
      r_move_err <= w_reject;
      if (w_accept) begin
        r_items <= i_move_items;
      end
      if (w_reject) begin
        r_err_code <= w_err;
      end
      if (w_commit) begin
        r_state <= w_state_next;
        r_count <= r_count + CNT_W'(1);
      end
      if (w_restart) begin
        r_state <= '0;
        r_count <= '0;
      end
    end
  end

  assign o_move_ready = (r_fsm == S_IDLE);
  assign o_state      = r_state;
  assign o_move_ok    = r_move_ok;
  assign o_move_err   = r_move_err;
  assign o_err_code   = r_err_code;
  assign o_move_count = r_count;
  assign o_solved     = (r_fsm == S_SOLVED);

`ifdef FORMAL
  // Viewing the position with the farmer flipped makes the checker examine
  // the bank the farmer is NOT on, i.e. the unattended one.
  logic [N_ITEMS:0] w_unattended_view;
  err_t             w_unattended_err;

  assign w_unattended_view = {~r_state[N_ITEMS], r_state[N_ITEMS-1:0]};

  river_check #(
    .N_ITEMS  (N_ITEMS),
    .BOAT_CAP (BOAT_CAP),
    .CONFLICT (CONFLICT)
  ) u_check_unattended (
    .i_state (w_unattended_view),
    .i_items ({N_ITEMS{1'b0}}),
    .o_err   (w_unattended_err)
  );

  a_ok_err_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(r_move_ok && r_move_err));

  a_no_unattended_conflict : assert property (@(posedge clk) disable iff (rst)
    r_move_ok |-> (w_unattended_err != ERR_CONFLICT));

  c_solved : cover property (@(posedge clk) o_solved);
`endif

endmodule : river_crossing
`default_nettype wire

// File: tb/tb_river_crossing.sv
`default_nettype none
// ============================================================================
// Module      : tb_river_crossing
// Description : Self-checking bench for river_crossing. Instance A uses the
//               default wolf/sheep/cabbage puzzle; instance B has no
//               conflicts and a two-move limit. Each move pushes the
//               reference result into a scoreboard that is popped when the
//               DUT pulses o_move_ok or o_move_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_river_crossing;

  typedef struct {
    logic       ok;
    logic [2:0] code;
    logic [3:0] st;
    logic [3:0] cnt;
    int         lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sel;

  logic       a_valid, a_restart, b_valid, b_restart;
  logic [2:0] a_items, b_items;
  logic       a_ready, a_ok, a_err, a_solved;
  logic       b_ready, b_ok, b_err, b_solved;
  logic [3:0] a_state, b_state;
  logic [2:0] a_code, b_code;
  logic [3:0] a_count;
  logic [1:0] b_count;

  logic       m_ready, m_ok, m_err, m_solved;
  logic [3:0] m_state, m_count;
  logic [2:0] m_code;

  int         n_cmp;
  int         n_bad;
  exp_t       sb[$];

  logic [3:0] mdl_st;
  logic [3:0] mdl_cnt;
  logic [2:0] mdl_code;

  river_crossing u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .i_move_valid (a_valid),
    .i_move_items (a_items),
    .i_restart    (a_restart),
    .o_move_ready (a_ready),
    .o_state      (a_state),
    .o_move_ok    (a_ok),
    .o_move_err   (a_err),
    .o_err_code   (a_code),
    .o_move_count (a_count),
    .o_solved     (a_solved)
  );

  river_crossing #(
    .CONFLICT  (9'h000),
    .MAX_MOVES (2)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .i_move_valid (b_valid),
    .i_move_items (b_items),
    .i_restart    (b_restart),
    .o_move_ready (b_ready),
    .o_state      (b_state),
    .o_move_ok    (b_ok),
    .o_move_err   (b_err),
    .o_err_code   (b_code),
    .o_move_count (b_count),
    .o_solved     (b_solved)
  );

  always_comb begin
    m_ready  = sel ? b_ready  : a_ready;
    m_ok     = sel ? b_ok     : a_ok;
    m_err    = sel ? b_err    : a_err;
    m_solved = sel ? b_solved : a_solved;
    m_state  = sel ? b_state  : a_state;
    m_code   = sel ? b_code   : a_code;
    m_count  = sel ? {2'b00, b_count} : a_count;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference of the legality rules for a 3-item puzzle.
  function automatic logic [2:0] ref_err(input logic [3:0] st, input logic [2:0] it,
                                         input int cnt, input int maxm, input logic [8:0] conf);
    int         pop;
    logic       f;
    logic [2:0] left;
    if (cnt == maxm) return 3'd4;
    pop = 0;
    for (int i = 0; i < 3; i++) if (it[i]) pop++;
    if (pop > 1) return 3'd1;
    f = st[3];
    for (int i = 0; i < 3; i++) if (it[i] && (st[i] != f)) return 3'd2;
    for (int i = 0; i < 3; i++) left[i] = (st[i] == f) && !it[i];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (i != j && left[i] && left[j] && conf[i*3+j]) return 3'd3;
    return 3'd0;
  endfunction

  task automatic do_move(input logic [2:0] it);
    logic [2:0] e;
    exp_t       x;
    exp_t       got;
    int         lat;
    logic       seen;
    e = ref_err(mdl_st, it, int'(mdl_cnt), sel ? 2 : 15, sel ? 9'h000 : 9'h088);
    x.ok = (e == 3'd0);
    if (e != 3'd0) begin
      mdl_code = e;
    end else begin
      mdl_st  = mdl_st ^ {1'b1, it};
      mdl_cnt = mdl_cnt + 4'd1;
    end
    x.code = mdl_code;
    x.st   = mdl_st;
    x.cnt  = mdl_cnt;
    x.lat  = x.ok ? 2 : 1;
    sb.push_back(x);

    @(negedge clk);
    for (int k = 0; k < 10 && !m_ready; k++) @(negedge clk);
    chk("ready_before_move", m_ready, 1);
    if (sel) begin b_valid = 1'b1; b_items = it; end
    else     begin a_valid = 1'b1; a_items = it; end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;

    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 5 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (m_ok || m_err) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("response_seen", seen, 1);
    got = sb.pop_front();
    if (seen) begin
      chk("move_ok", m_ok, got.ok);
      chk("move_err", m_err, !got.ok);
      chk("latency", lat, got.lat);
      chk("err_code", m_code, got.code);
      chk("state", m_state, got.st);
      chk("move_count", m_count, got.cnt);
      @(posedge clk);
      #1;
      chk("pulse_one_cycle", {m_ok, m_err}, 2'b00);
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    if (sel) b_restart = 1'b1; else a_restart = 1'b1;
    @(posedge clk);
    #1;
    a_restart = 1'b0;
    b_restart = 1'b0;
    mdl_st  = 4'h0;
    mdl_cnt = 4'h0;
  endtask

  logic [2:0] solve_seq [7];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel = 1'b0;
    a_valid = 1'b0; a_items = 3'b000; a_restart = 1'b0;
    b_valid = 1'b0; b_items = 3'b000; b_restart = 1'b0;
    mdl_st = 4'h0; mdl_cnt = 4'h0; mdl_code = 3'd0;
    solve_seq = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};

    // Reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", a_state, 4'h0);
    chk("rst_count", a_count, 4'h0);
    chk("rst_code", a_code, 3'd0);
    chk("rst_pulses", {a_ok, a_err}, 2'b00);
    chk("rst_solved", a_solved, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", a_ready, 1);

    // Rejections and a side error after a round trip.
    do_move(3'b100);
    chk("wolf_first_code", a_code, 3'd3);
    do_move(3'b011);
    chk("capacity_code", a_code, 3'd1);
    do_move(3'b010);
    do_move(3'b000);
    do_move(3'b010);
    chk("side_code", a_code, 3'd2);

    // Restart from IDLE keeps the last error reason.
    do_restart();
    chk("restart_idle_state", a_state, 4'h0);
    chk("restart_idle_count", a_count, 4'h0);
    chk("restart_idle_code", a_code, 3'd2);

    // Full solution.
    foreach (solve_seq[i]) do_move(solve_seq[i]);
    chk("solved_state", a_state, 4'hF);
    chk("solved_flag", a_solved, 1);
    chk("solved_count", a_count, 4'd7);
    chk("solved_not_ready", a_ready, 0);

    // Requests are ignored while solved.
    @(negedge clk);
    a_valid = 1'b1;
    a_items = 3'b001;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("solved_ignores_move", {a_ok, a_err}, 2'b00);
    end
    a_valid = 1'b0;
    chk("solved_state_held", a_state, 4'hF);

    // Restart from SOLVED.
    do_restart();
    chk("restart_solved_state", a_state, 4'h0);
    chk("restart_solved_flag", a_solved, 0);
    chk("restart_solved_code", a_code, 3'd2);
    chk("restart_solved_ready", a_ready, 1);

    // Reset while the move sits in COMMIT.
    @(negedge clk);
    a_valid = 1'b1;
    a_items = 3'b010;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_commit_state", a_state, 4'h0);
    chk("rst_commit_ok", a_ok, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_commit_ready", a_ready, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_commit_no_pulse", {a_ok, a_err}, 2'b00);
    end
    chk("rst_commit_state_after", a_state, 4'h0);
    chk("rst_commit_code", a_code, 3'd0);

    // Move limit on the conflict-free instance.
    sel = 1'b1;
    mdl_st = 4'h0; mdl_cnt = 4'h0; mdl_code = 3'd0;
    do_move(3'b000);
    do_move(3'b000);
    do_move(3'b000);
    chk("limit_code", b_code, 3'd4);
    chk("limit_count", b_count, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_river_crossing
`default_nettype wire
